// File: rtl/bert_ctrl.sv
// PRBS-7 bit-error-rate checker: seeds an LFSR from the recovered stream, then
// compares each recovered bit with the prediction and tracks lock per window.
module bert_ctrl #(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic        clk_x8,
  input  logic        rst,
  input  logic        d_in,
  input  logic        d_valid,
  input  logic        enable,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [31:0] bit_count,
  output logic [7:0]  resync_count
);

  localparam int unsigned WCW = $clog2(WINDOW);
  localparam int unsigned EW  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [6:0]      r_s, w_s_nxt;
  logic [2:0]      r_seed_cnt, w_seed_nxt;
  logic [WCW-1:0]  r_win_cnt, w_win_nxt;
  logic [EW-1:0]   r_win_err, w_werr_nxt;
  logic            r_locked, w_locked_nxt;
  logic            r_err_pulse, w_pulse_nxt;
  logic [31:0]     r_err_count, w_errc_nxt;
  logic [31:0]     r_bit_count, w_bitc_nxt;
  logic [7:0]      r_resync_count, w_rsc_nxt;

  logic            w_pred;
  logic            w_err;
  logic [6:0]      w_seed_shift;
  logic            w_win_end;
  logic [EW-1:0]   w_werr_sat;
  logic            w_inc_bit;
  logic            w_inc_err;
  logic            w_inc_rsc;

  assign w_pred       = r_s[6] ^ r_s[5];
  assign w_err        = d_in ^ w_pred;
  assign w_seed_shift = {r_s[5:0], d_in};
  assign w_win_end    = (r_win_cnt == WCW'(WINDOW - 1));
  // Window error count including the current bit, pinned at the loss threshold
  assign w_werr_sat   = (r_win_err >= EW'(LOSS_THRESH)) ? r_win_err
                                                        : r_win_err + EW'(w_err);

  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_seed_nxt   = r_seed_cnt;
    w_win_nxt    = r_win_cnt;
    w_werr_nxt   = r_win_err;
    w_locked_nxt = r_locked;
    w_pulse_nxt  = 1'b0;
    w_inc_bit    = 1'b0;
    w_inc_err    = 1'b0;
    w_inc_rsc    = 1'b0;
    w_errc_nxt   = r_err_count;
    w_bitc_nxt   = r_bit_count;
    w_rsc_nxt    = r_resync_count;

    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SEED;
          w_seed_nxt  = '0;
        end
        ST_SEED: begin
          if (d_valid) begin
            w_s_nxt = w_seed_shift;
            if (r_seed_cnt == 3'd6) begin
              // An all-zero seed would lock onto a dead line; keep seeding
              w_seed_nxt = '0;
              if (w_seed_shift != 7'd0) begin
                w_state_nxt = ST_CHECK;
                w_win_nxt   = '0;
                w_werr_nxt  = '0;
              end
            end else begin
              w_seed_nxt = r_seed_cnt + 3'd1;
            end
          end
        end
        ST_CHECK: begin
          if (d_valid) begin
            w_s_nxt     = {r_s[5:0], w_pred};
            w_win_nxt   = r_win_cnt + WCW'(1);
            w_werr_nxt  = w_werr_sat;
            w_inc_bit   = r_locked;
            w_inc_err   = r_locked & w_err;
            w_pulse_nxt = r_locked & w_err;
            if (w_win_end) begin
              w_win_nxt  = '0;
              w_werr_nxt = '0;
              if (w_werr_sat >= EW'(LOSS_THRESH)) begin
                w_state_nxt  = ST_SEED;
                w_seed_nxt   = '0;
                w_locked_nxt = 1'b0;
                w_inc_rsc    = r_locked;
              end else begin
                w_locked_nxt = 1'b1;
              end
            end
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_locked_nxt = 1'b0;
        end
      endcase
    end

    // Saturating statistics; clear wins over a same-cycle increment
    if (clear) begin
      w_errc_nxt = '0;
      w_bitc_nxt = '0;
      w_rsc_nxt  = '0;
    end else begin
      if (w_inc_err && (r_err_count != '1))    w_errc_nxt = r_err_count + 32'd1;
      if (w_inc_bit && (r_bit_count != '1))    w_bitc_nxt = r_bit_count + 32'd1;
      if (w_inc_rsc && (r_resync_count != '1)) w_rsc_nxt  = r_resync_count + 8'd1;
    end
  end

  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_s            <= '0;
      r_seed_cnt     <= '0;
      r_win_cnt      <= '0;
      r_win_err      <= '0;
      r_locked       <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_err_count    <= '0;
      r_bit_count    <= '0;
      r_resync_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_s            <= w_s_nxt;
      r_seed_cnt     <= w_seed_nxt;
      r_win_cnt      <= w_win_nxt;
      r_win_err      <= w_werr_nxt;
      r_locked       <= w_locked_nxt;
      r_err_pulse    <= w_pulse_nxt;
      r_err_count    <= w_errc_nxt;
      r_bit_count    <= w_bitc_nxt;
      r_resync_count <= w_rsc_nxt;
    end
  end

  assign locked       = r_locked;
  assign err_pulse    = r_err_pulse;
  assign err_count    = r_err_count;
  assign bit_count    = r_bit_count;
  assign resync_count = r_resync_count;

endmodule

// File: tb/tb_bert_ctrl.sv
// Directed bench for bert_ctrl: lock, error counting, loss/relock, clear,
// enable drop, dead line, saturation and asynchronous reset.
module tb_bert_ctrl;

  logic        clk_x8 = 1'b0;
  logic        rst;
  logic        d_in;
  logic        d_valid;
  logic        enable;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;
  logic [7:0]  resync_count;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          pulse_cnt = 0;
  logic [6:0]  g = 7'b1010101;
  logic        b;

  bert_ctrl #(.WINDOW(64), .LOSS_THRESH(8)) dut (
    .clk_x8       (clk_x8),
    .rst          (rst),
    .d_in         (d_in),
    .d_valid      (d_valid),
    .enable       (enable),
    .clear        (clear),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .bit_count    (bit_count),
    .resync_count (resync_count)
  );

  always #5 clk_x8 = ~clk_x8;

  always @(negedge clk_x8) if (err_pulse) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_x8);
    #1;
  endtask

  task automatic gen_bit(output logic o);
    o = g[6] ^ g[5];
    g = {g[5:0], o};
  endtask

  // One strobe, then seven idle cycles (d_valid every 8th cycle)
  task automatic send(input logic bit_v, input logic clr);
    d_in    = bit_v;
    d_valid = 1'b1;
    clear   = clr;
    tick();
    d_valid = 1'b0;
    clear   = 1'b0;
    repeat (7) tick();
  endtask

  // n PRBS bits, the first ninv of them inverted
  task automatic send_prbs(input int n, input int ninv);
    logic x;
    for (int i = 0; i < n; i++) begin
      gen_bit(x);
      send((i < ninv) ? ~x : x, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; enable = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse",  32'(err_pulse), 32'd0);
    check("rst_errc",   err_count, 32'd0);
    check("rst_bitc",   bit_count, 32'd0);
    check("rst_rsc",    32'(resync_count), 32'd0);
    rst = 1'b0;
    tick();

    // Initial lock: 7 seed bits + one 64-bit window
    enable = 1'b1;
    tick();
    send_prbs(70, 0);
    check("prelock_locked", 32'(locked), 32'd0);
    send_prbs(1, 0);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_bitc",   bit_count, 32'd0);
    check("lock_errc",   err_count, 32'd0);
    send_prbs(5, 0);
    check("clean_bitc", bit_count, 32'd5);

    // Single inverted bit
    send_prbs(1, 1);
    check("single_errc",   err_count, 32'd1);
    check("single_pulses", 32'(pulse_cnt), 32'd1);
    check("single_locked", 32'(locked), 32'd1);
    check("single_bitc",   bit_count, 32'd6);
    send_prbs(58, 0);
    check("win2_locked", 32'(locked), 32'd1);
    check("win2_bitc",   bit_count, 32'd64);

    // Eight errors in one window -> loss at window end
    send_prbs(8, 8);
    check("burst_locked_mid", 32'(locked), 32'd1);
    send_prbs(56, 0);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_rsc",    32'(resync_count), 32'd1);
    check("loss_errc",   err_count, 32'd9);
    check("loss_bitc",   bit_count, 32'd128);
    check("loss_pulses", 32'(pulse_cnt), 32'd9);

    // Relock after 71 clean bits
    send_prbs(70, 0);
    check("relock_pre", 32'(locked), 32'd0);
    send_prbs(1, 0);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_bitc",   bit_count, 32'd128);
    check("relock_rsc",    32'(resync_count), 32'd1);

    // clear coincident with a counted error
    gen_bit(b);
    send(~b, 1'b1);
    check("clear_errc", err_count, 32'd0);
    check("clear_bitc", bit_count, 32'd0);
    check("clear_rsc",  32'(resync_count), 32'd0);
    check("clear_locked", 32'(locked), 32'd1);
    send_prbs(3, 0);
    check("postclear_bitc", bit_count, 32'd3);

    // enable dropped mid-window
    enable = 1'b0;
    tick();
    check("dis_locked", 32'(locked), 32'd0);
    send_prbs(1, 0);
    check("dis_bitc", bit_count, 32'd3);
    check("dis_errc", err_count, 32'd0);
    check("dis_rsc",  32'(resync_count), 32'd0);

    // Dead (all-zero) line never locks
    enable = 1'b1;
    for (int i = 0; i < 80; i++) send(1'b0, 1'b0);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_rsc",    32'(resync_count), 32'd0);
    check("zero_bitc",   bit_count, 32'd3);

    // Restart seeding, lock, then saturate err_count
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    send_prbs(71, 0);
    check("sat_locked", 32'(locked), 32'd1);
    force dut.r_err_count = 32'hFFFF_FFFE;
    tick();
    release dut.r_err_count;
    tick();
    send_prbs(1, 1);
    check("sat_errc1", err_count, 32'hFFFF_FFFF);
    send_prbs(2, 2);
    check("sat_errc2", err_count, 32'hFFFF_FFFF);
    check("sat_locked2", 32'(locked), 32'd1);

    // Asynchronous reset while a pulse is high, mid-CHECK
    gen_bit(b);
    d_in    = ~b;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    check("pre_arst_pulse", 32'(err_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_pulse",  32'(err_pulse), 32'd0);
    check("arst_errc",   err_count, 32'd0);
    check("arst_bitc",   bit_count, 32'd0);
    check("arst_rsc",    32'(resync_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bert_ctrl.md
BERT_CTRL -- requirements
Module: bert_ctrl

Interface
REQ-001 Parameter WINDOW, default 64: recovered bits per error-evaluation window; power of two, 8..1024.
REQ-002 Parameter LOSS_THRESH, default 8: window error count at or above which lock is declared lost.
REQ-003 clk_x8  in  1  sample clock, the single clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 d_in  in  1  recovered data bit from the CDR.
REQ-006 d_valid  in  1  one-cycle strobe; d_in is a new recovered bit when high.
REQ-007 enable  in  1  level; high runs the checker, low forces IDLE.
REQ-008 clear  in  1  one-cycle strobe; zeroes err_count, bit_count and resync_count.
REQ-009 locked  out  1  high while the checker is in CHECK with a qualified window.
REQ-010 err_pulse  out  1  one-cycle pulse per counted bit error.
REQ-011 err_count  out  32  saturating count of bit errors while locked.
REQ-012 bit_count  out  32  saturating count of bits compared while locked.
REQ-013 resync_count  out  8  saturating count of lock losses.

Function
REQ-014 The reference pattern shall be PRBS-7, x^7+x^6+1, 7-bit register s, with predicted bit p = s[6]^s[5].
REQ-015 The state machine shall have states IDLE, SEED and CHECK; only d_valid cycles advance the LFSR, seed counter and window counter.
REQ-016 IDLE: locked=0; go to SEED on the cycle after enable is sampled high, with the seed counter zeroed.
REQ-017 SEED: on each d_valid, s <= {s[5:0], d_in} and increment the seed counter; after the 7th valid bit go to CHECK, with window counter and window error counter zeroed.
REQ-018 SEED with all-zero s after 7 bits: remain in SEED, restart the seed counter, and do not increment resync_count.
REQ-019 CHECK: on each d_valid, s <= {s[5:0], p}, err = d_in XOR p, window counter += 1, window error counter += err; the window error counter saturates at LOSS_THRESH.
REQ-020 Window end = d_valid on which the window counter reaches WINDOW (wraps to 0); the bit on that strobe is included in the window.
REQ-021 Window end, window errors (including that bit) >= LOSS_THRESH: go to SEED; locked <= 0; resync_count += 1 if locked was high.
REQ-022 Window end, window errors < LOSS_THRESH: locked <= 1; stay in CHECK; window counters restart.
REQ-023 While locked=1, each d_valid increments bit_count, and each err increments err_count and asserts err_pulse on the following cycle; neither counter changes while locked=0.
REQ-024 First-window errors (locked=0) shall not be counted.
REQ-025 All three counters shall saturate at all-ones and never wrap.
REQ-026 clear shall zero all three counters; it takes priority over a same-cycle increment and does not affect the state, s or locked.
REQ-027 enable low in any state: IDLE on the next edge, locked=0, counters hold, and a pending err_pulse still fires.
REQ-028 Outputs shall be registered; locked shall rise one cycle after the qualifying window-end strobe.

Reset
REQ-029 rst high shall asynchronously force IDLE, s=0, all counters 0, locked=0 and err_pulse=0.
REQ-030 Release from rst shall be synchronous to clk_x8; the first transition out of IDLE occurs no earlier than the first edge after deassertion.

Verification
REQ-031 Clean PRBS-7 stream, d_valid every 8th cycle, enable=1 -> locked=1 after 7+64 valid bits; err_count=0; bit_count grows by 1 per strobe.
REQ-032 Locked, single bit inverted -> exactly one err_pulse; err_count=1; locked stays 1.
REQ-033 Locked, 8 inverted bits within one window -> locked=0 at window end, resync_count=1, relock after 71 further clean bits.
REQ-034 All-zero input stream -> FSM stays in SEED, locked=0, resync_count=0.
REQ-035 clear asserted on the same cycle as a counted error -> err_count=0 afterwards; enable dropped mid-window -> IDLE next cycle, counters hold.
REQ-036 err_count preloaded near 0xFFFFFFFF by forcing, then repeated errors -> err_count holds at 0xFFFFFFFF; rst asserted mid-CHECK -> all outputs 0 immediately, without waiting for a clock edge.
